control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Fetch/decode/execute sequencer that sits directly upstream of the 8-bit datapath (16x8 register file plus ALU).
- Fetches 16-bit instructions from an instruction memory over a req/valid handshake.
- Decodes each instruction and drives the datapath control inputs: alu_en, alu_opcode, ra/rb/write addresses, imm_value, write_en.
- Latches the datapath's alu_zero/alu_carry into flag registers, which are used for conditional branches.

Parameters:
PC_WIDTH, 8, width of program counter and instruction address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset; asynchronous, active-low (0 = reset asserted)
run  in  1  level enable; sequencer fetches while high
imem_req  out  1  instruction fetch request
imem_addr  out  PC_WIDTH  fetch address (= PC)
imem_valid  in  1  imem_data valid this cycle
imem_data  in  16  fetched instruction
alu_zero  in  1  datapath ALU zero flag (combinational)
alu_carry  in  1  datapath ALU carry flag (combinational)
alu_en  out  1  datapath write-back selects ALU result
alu_opcode  out  3  ALU operation (ADD..SHR encoding, 000..111)
ra_addr  out  4  register read port A
rb_addr  out  4  register read port B
write_addr  out  4  register write address
imm_value  out  8  immediate write data
write_en  out  1  register write strobe
flag_z  out  1  latched zero flag
flag_c  out  1  latched carry flag
halted  out  1  high in HALT state

Behaviour:
- Encoding when bit 15 = 1 (ALU instruction): [14:12] alu op, [11:8] rd, [7:4] ra, [3:0] rb.
- Encoding when bit 15 = 0: [14:12] class.
  - 000 NOP.
  - 001 LDI: [11:8] rd, [7:0] imm.
  - 010 JMP: [7:0] target.
  - 011 BZ: [7:0] target; taken if flag_z.
  - 100 BC: [7:0] target; taken if flag_c.
  - 101, 110: reserved, execute as NOP.
  - 111 HALT.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE: if run=1, go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=PC held stable. On imem_valid=1, capture IR, load control registers, go to EXEC. Wait states are unlimited.
  - EXEC: lasts exactly one cycle and the controls are valid for the whole cycle. The datapath writes at the closing edge. Next state is HALT if the instruction is HALT; otherwise FETCH if run=1, else IDLE.
  - HALT: exits only through reset; run is ignored.
- Control outputs are registered, loaded on the FETCH->EXEC edge.
  - write_en=1 in EXEC for LDI and ALU instructions only.
  - alu_en=1 for ALU instructions only.
  - write_en and alu_en are cleared on the EXEC exit edge.
  - Address, opcode and imm outputs hold their last values outside EXEC.
- Flags: at the EXEC exit edge of ALU instructions only, flag_z <= alu_zero and flag_c <= alu_carry. Other instructions leave the flags unchanged.
- PC: updated at the EXEC exit edge.
  - Taken JMP/BZ/BC: PC <= target.
  - Otherwise: PC <= PC+1, wrapping modulo 2^PC_WIDTH (0xFF -> 0x00).
  - HALT does not advance the PC.
  - The 8-bit target is zero-extended or truncated to PC_WIDTH.
- A write to rd=0 is issued normally; the datapath discards it.
- imem_valid outside FETCH is ignored.
- Reset values (asynchronous, take effect immediately including mid-EXEC):
  - state=IDLE, PC=RESET_PC, IR=0.
  - write_en=0, alu_en=0, imem_req=0.
  - All addresses, opcode and imm = 0.
  - flag_z=0, flag_c=0, halted=0.
- Latency: 2 cycles per instruction with zero-wait memory (FETCH+EXEC), plus memory wait cycles.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined: adds input port step. IDLE->FETCH additionally requires a one-cycle step pulse. After EXEC the FSM always returns to IDLE, so exactly one instruction runs per step (run must also be 1).
- When undefined: no step port; behaviour as above.

Decomposition:
- Shared package:
  - ALU opcode constants, common with the datapath.
  - Instruction class constants.
  - Field bit positions.
  - FSM state encoding.
  - 16-bit instruction width constant.
- One natural sub-module, instr_decoder: combinational IR -> control fields, write_en, alu_en, branch-type and halt indications. control_sequencer owns the FSM, PC, IR, flags and output registers.

Test Plan:
1. Assert rst=0 mid-EXEC of LDI -> write_en=0, imem_req=0, imem_addr=0x00, halted=0 within the same cycle. Release rst with run=1 -> imem_req=1 on the next cycle.
2. Program 0x1105, 0x1203, 0x8312 -> EXEC cycles in order:
   - write_addr=1, imm_value=0x05, write_en=1, alu_en=0;
   - write_addr=2, imm_value=0x03;
   - alu_en=1, alu_opcode=000, ra=1, rb=2, write_addr=3, write_en=1.
3. Model alu_zero=1 during the EXEC of 0x9411 (SUB r4,r1,r1), then fetch 0x3010 -> flag_z=1 and the next imem_addr=0x10. Repeat with alu_zero=0 -> next imem_addr = BZ address + 1.
4. Delay imem_valid by 3 cycles -> imem_req stays high, imem_addr stays stable, write_en stays 0 throughout, and EXEC follows exactly one cycle after valid.
5. JMP 0xFF (0x20FF), NOP at 0xFF -> the following fetch address is 0x00. Drop run during EXEC -> FSM enters IDLE and imem_req=0.
6. HALT (0x7000) -> halted=1, imem_req=0 indefinitely, and PC is unchanged despite run toggling. Only rst=0 restores IDLE.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared constants and types for the control sequencer
// ALU opcodes match the datapath encoding; field positions describe the 16-bit instruction word.
package control_sequencer_pkg;

  localparam int INSTR_W = 16;

  localparam int ALU_BIT = 15;
  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'b000,
    CLS_LDI  = 3'b001,
    CLS_JMP  = 3'b010,
    CLS_BZ   = 3'b011,
    CLS_BC   = 3'b100,
    CLS_RSV5 = 3'b101,
    CLS_RSV6 = 3'b110,
    CLS_HALT = 3'b111
  } instr_class_e;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_JMP,
    BR_BZ,
    BR_BC
  } branch_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_e;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction fetch and datapath control bundle
// master is the sequencer side, slave is the memory/datapath side.
interface control_sequencer_if
  import control_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_valid;
  logic [INSTR_W-1:0]  imem_data;
  logic                alu_zero;
  logic                alu_carry;
  logic                alu_en;
  logic [2:0]          alu_opcode;
  logic [3:0]          ra_addr;
  logic [3:0]          rb_addr;
  logic [3:0]          write_addr;
  logic [7:0]          imm_value;
  logic                write_en;

  modport master (
    output imem_req, imem_addr, alu_en, alu_opcode, ra_addr, rb_addr,
           write_addr, imm_value, write_en,
    input  imem_valid, imem_data, alu_zero, alu_carry
  );

  modport slave (
    input  imem_req, imem_addr, alu_en, alu_opcode, ra_addr, rb_addr,
           write_addr, imm_value, write_en,
    output imem_valid, imem_data, alu_zero, alu_carry
  );
endinterface

// File: rtl/control_sequencer_instr_decoder.sv
// rtl/control_sequencer_instr_decoder.sv - combinational instruction decode
// Register fields are extracted raw for every instruction; only the strobes depend on the class.
module control_sequencer_instr_decoder
  import control_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [2:0]         alu_op,
  output logic [3:0]         rd,
  output logic [3:0]         ra,
  output logic [3:0]         rb,
  output logic [7:0]         imm,
  output logic               write_en,
  output logic               alu_en,
  output branch_e            branch,
  output logic               is_halt
);
  instr_class_e cls;
  logic         is_alu;

  always_comb begin
    is_alu   = ir[ALU_BIT];
    cls      = instr_class_e'(ir[OP_MSB:OP_LSB]);
    alu_op   = ir[OP_MSB:OP_LSB];
    rd       = ir[RD_MSB:RD_LSB];
    ra       = ir[RA_MSB:RA_LSB];
    rb       = ir[RB_MSB:RB_LSB];
    imm      = ir[IMM_MSB:IMM_LSB];
    alu_en   = is_alu;
    write_en = is_alu || (cls == CLS_LDI);
    branch   = BR_NONE;
    is_halt  = 1'b0;
    if (!is_alu) begin
      case (cls)
        CLS_JMP:  branch  = BR_JMP;
        CLS_BZ:   branch  = BR_BZ;
        CLS_BC:   branch  = BR_BC;
        CLS_HALT: is_halt = 1'b1;
        default:  ;
      endcase
    end
  end
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute sequencer for the 8-bit datapath
// Optional SINGLE_STEP_EN: adds a step input and runs one instruction per step pulse.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
`ifdef SINGLE_STEP_EN
  input  logic                step,
`endif
  control_sequencer_if.master bus,
  output logic                flag_z,
  output logic                flag_c,
  output logic                halted
);
  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [2:0]          op_q;
  logic [3:0]          ra_q, rb_q, wa_q;
  logic [7:0]          imm_q;
  logic                we_q, ae_q;
  logic                accept, exec_done, br_taken, start, cont;

  logic [INSTR_W-1:0]  dec_in;
  logic [2:0]          d_op;
  logic [3:0]          d_rd, d_ra, d_rb;
  logic [7:0]          d_imm;
  logic                d_we, d_ae, d_halt;
  branch_e             d_branch;

  // Decode the incoming word while fetching, the held IR while executing.
  assign dec_in = (state_q == ST_FETCH) ? bus.imem_data : ir_q;

  control_sequencer_instr_decoder u_dec (
    .ir       (dec_in),
    .alu_op   (d_op),
    .rd       (d_rd),
    .ra       (d_ra),
    .rb       (d_rb),
    .imm      (d_imm),
    .write_en (d_we),
    .alu_en   (d_ae),
    .branch   (d_branch),
    .is_halt  (d_halt)
  );

`ifdef SINGLE_STEP_EN
  assign start = run && step;
  assign cont  = 1'b0;
`else
  assign start = run;
  assign cont  = run;
`endif

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    exec_done = 1'b0;
    br_taken  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec_done = 1'b1;
        case (d_branch)
          BR_JMP:  br_taken = 1'b1;
          BR_BZ:   br_taken = flag_z;
          BR_BC:   br_taken = flag_c;
          default: br_taken = 1'b0;
        endcase
        if (d_halt)    state_d = ST_HALT;
        else if (cont) state_d = ST_FETCH;
        else           state_d = ST_IDLE;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= PC_WIDTH'(RESET_PC);
      ir_q   <= '0;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      wa_q   <= '0;
      imm_q  <= '0;
      we_q   <= 1'b0;
      ae_q   <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      if (accept) begin
        ir_q  <= bus.imem_data;
        op_q  <= d_op;
        ra_q  <= d_ra;
        rb_q  <= d_rb;
        wa_q  <= d_rd;
        imm_q <= d_imm;
        we_q  <= d_we;
        ae_q  <= d_ae;
      end
      if (exec_done) begin
        we_q <= 1'b0;
        ae_q <= 1'b0;
        // ae_q still marks the ALU instruction on its closing edge.
        if (ae_q) begin
          flag_z <= bus.alu_zero;
          flag_c <= bus.alu_carry;
        end
        if (!d_halt) pc_q <= br_taken ? PC_WIDTH'(d_imm) : pc_q + PC_WIDTH'(1);
      end
    end
  end

  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.alu_en     = ae_q;
  assign bus.alu_opcode = op_q;
  assign bus.ra_addr    = ra_q;
  assign bus.rb_addr    = rb_q;
  assign bus.write_addr = wa_q;
  assign bus.imm_value  = imm_q;
  assign bus.write_en   = we_q;
  assign halted         = (state_q == ST_HALT);
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
// Default build only (SINGLE_STEP_EN undefined); step is tied high when the macro is set.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic run;
  logic flag_z, flag_c, halted;
`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  control_sequencer_if #(.PC_WIDTH(8)) bus ();

  control_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
`ifdef SINGLE_STEP_EN
    .step   (step),
`endif
    .bus    (bus),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .halted (halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural reference state
  logic [7:0]  m_pc;
  logic        m_fz, m_fc;
  logic [15:0] mem [256];

  logic       obs_we, obs_ae;
  logic [3:0] obs_wa, obs_ra, obs_rb;
  logic [7:0] obs_imm;
  logic [2:0] obs_op;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    int          waits;
    logic        z, c, we, ae;
    logic [3:0]  wa;
    logic [7:0]  imm;
    logic [2:0]  op;
    logic [3:0]  ra, rb;
    logic        fz, fc;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at posedge+1 of a FETCH cycle; returns at posedge+1 after the EXEC exit edge.
  task automatic do_instr(input logic [15:0] instr, input int waits, input logic z,
                          input logic c, input logic drop);
    logic       is_alu, taken;
    logic [2:0] cls;
    is_alu = instr[15];
    cls    = instr[14:12];
    bus.imem_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      bus.imem_data = 16'($urandom);
      @(negedge clk);
      chk("wait_req", 32'(bus.imem_req), 1);
      chk("wait_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("wait_we", 32'(bus.write_en), 0);
      @(posedge clk); #1;
    end
    bus.imem_valid = 1'b1;
    bus.imem_data  = instr;
    @(negedge clk);
    chk("fetch_req", 32'(bus.imem_req), 1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
    @(posedge clk); #1;
    bus.imem_valid = 1'($urandom);
    bus.imem_data  = 16'($urandom);
    bus.alu_zero   = z;
    bus.alu_carry  = c;
    if (drop) run = 1'b0;
    @(negedge clk);
    chk("exec_we", 32'(bus.write_en), 32'(is_alu || cls == 3'd1));
    chk("exec_ae", 32'(bus.alu_en), 32'(is_alu));
    chk("exec_req", 32'(bus.imem_req), 0);
    chk("exec_halted", 32'(halted), 0);
    if (is_alu) begin
      chk("exec_op", 32'(bus.alu_opcode), 32'(cls));
      chk("exec_wa", 32'(bus.write_addr), 32'(instr[11:8]));
      chk("exec_ra", 32'(bus.ra_addr), 32'(instr[7:4]));
      chk("exec_rb", 32'(bus.rb_addr), 32'(instr[3:0]));
    end else if (cls == 3'd1) begin
      chk("exec_wa", 32'(bus.write_addr), 32'(instr[11:8]));
      chk("exec_imm", 32'(bus.imm_value), 32'(instr[7:0]));
    end
    obs_we = bus.write_en;  obs_ae = bus.alu_en;  obs_wa = bus.write_addr;
    obs_ra = bus.ra_addr;   obs_rb = bus.rb_addr; obs_imm = bus.imm_value;
    obs_op = bus.alu_opcode;
    taken = !is_alu && (cls == 3'd2 || (cls == 3'd3 && m_fz) || (cls == 3'd4 && m_fc));
    if (is_alu) begin
      m_fz = z;
      m_fc = c;
    end
    if (!(!is_alu && cls == 3'd7)) m_pc = taken ? instr[7:0] : m_pc + 8'd1;
    @(posedge clk); #1;
    bus.imem_valid = 1'b0;
    chk("post_we", 32'(bus.write_en), 0);
    chk("post_fz", 32'(flag_z), 32'(m_fz));
    chk("post_fc", 32'(flag_c), 32'(m_fc));
  endtask

  // Called with run low and the FSM in IDLE; leaves it at posedge+1 of FETCH.
  task automatic resume(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("idle_req", 32'(bus.imem_req), 0);
      @(posedge clk); #1;
    end
    run = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(bus.imem_req), 0);
    chk("idle_addr", 32'(bus.imem_addr), 32'(m_pc));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  initial begin
    logic [15:0] r;
    logic        drop;
    tbl[0]  = '{8'h00, 16'h1105, 0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'h05, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h01, 16'h1203, 0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 8'h03, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'h02, 16'h8312, 0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 8'h00, 3'd0, 4'd1, 4'd2, 1'b0, 1'b1};
    tbl[3]  = '{8'h03, 16'h9411, 0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 8'h00, 3'd1, 4'd1, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{8'h04, 16'h3010, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{8'h10, 16'h9411, 1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 8'h00, 3'd1, 4'd1, 4'd1, 1'b0, 1'b0};
    tbl[6]  = '{8'h11, 16'h3010, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{8'h12, 16'h4020, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{8'h13, 16'hA511, 0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 8'h00, 3'd2, 4'd1, 4'd1, 1'b1, 1'b1};
    tbl[9]  = '{8'h14, 16'h4020, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[10] = '{8'h20, 16'h5000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[11] = '{8'h21, 16'h0000, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[12] = '{8'h22, 16'h20FF, 3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[13] = '{8'hFF, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[14] = '{8'h00, 16'hF0AB, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 3'd7, 4'hA, 4'hB, 1'b0, 1'b0};
    tbl[15] = '{8'h01, 16'h10FF, 0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'hFF, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0};

    rst = 1'b1; run = 1'b0;
    bus.imem_valid = 1'b0; bus.imem_data = '0; bus.alu_zero = 1'b0; bus.alu_carry = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    chk("rst_we", 32'(bus.write_en), 0);
    chk("rst_ae", 32'(bus.alu_en), 0);
    chk("rst_op", 32'(bus.alu_opcode), 0);
    chk("rst_wa", 32'(bus.write_addr), 0);
    chk("rst_imm", 32'(bus.imm_value), 0);
    chk("rst_flags", 32'({flag_z, flag_c}), 0);
    chk("rst_halted", 32'(halted), 0);
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b1;
    @(negedge clk);
    chk("start_req_idle", 32'(bus.imem_req), 0);
    @(posedge clk); #1;

    // Reset asserted in the middle of an LDI execute cycle
    bus.imem_valid = 1'b1; bus.imem_data = 16'h1105;
    @(posedge clk); #1;
    bus.imem_valid = 1'b0;
    @(negedge clk);
    chk("ldi_we_before_rst", 32'(bus.write_en), 1);
    rst = 1'b0;
    #1;
    chk("midrst_we", 32'(bus.write_en), 0);
    chk("midrst_req", 32'(bus.imem_req), 0);
    chk("midrst_addr", 32'(bus.imem_addr), 0);
    chk("midrst_halted", 32'(halted), 0);
    chk("midrst_wa", 32'(bus.write_addr), 0);
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b1;
    @(negedge clk);
    chk("rel_req_idle", 32'(bus.imem_req), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_req_fetch", 32'(bus.imem_req), 1);
    @(posedge clk); #1;
    m_pc = 8'h00; m_fz = 1'b0; m_fc = 1'b0;

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].pc));
      @(posedge clk); #1;
      do_instr(tbl[i].instr, tbl[i].waits, tbl[i].z, tbl[i].c, 1'b0);
      chk($sformatf("vec%0d_we", i), 32'(obs_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d_ae", i), 32'(obs_ae), 32'(tbl[i].ae));
      if (tbl[i].we) chk($sformatf("vec%0d_wa", i), 32'(obs_wa), 32'(tbl[i].wa));
      if (tbl[i].we && !tbl[i].ae) chk($sformatf("vec%0d_imm", i), 32'(obs_imm), 32'(tbl[i].imm));
      if (tbl[i].ae) begin
        chk($sformatf("vec%0d_op", i), 32'(obs_op), 32'(tbl[i].op));
        chk($sformatf("vec%0d_ra", i), 32'(obs_ra), 32'(tbl[i].ra));
        chk($sformatf("vec%0d_rb", i), 32'(obs_rb), 32'(tbl[i].rb));
      end
      chk($sformatf("vec%0d_fz", i), 32'(flag_z), 32'(tbl[i].fz));
      chk($sformatf("vec%0d_fc", i), 32'(flag_c), 32'(tbl[i].fc));
    end
    @(negedge clk);
    chk("vec_end_addr", 32'(bus.imem_addr), 32'h02);
    @(posedge clk); #1;

    // run dropped during EXEC returns to IDLE
    do_instr(16'h0000, 0, 1'b0, 1'b0, 1'b1);
    resume(2);

    // Randomized program against the architectural model
    for (int i = 0; i < 256; i++) begin
      r = 16'($urandom);
      if (!r[15] && r[14:12] == 3'd7) r[14:12] = 3'd0;
      mem[i] = r;
    end
    for (int n = 0; n < 200; n++) begin
      drop = ($urandom_range(0, 7) == 0);
      do_instr(mem[m_pc], int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), drop);
      if (drop) resume(int'($urandom_range(0, 2)));
    end

    // HALT holds until reset regardless of run or imem_valid
    do_instr(16'h7000, 1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run = 1'(i);
      bus.imem_valid = 1'(i);
      @(negedge clk);
      chk("halt_halted", 32'(halted), 1);
      chk("halt_req", 32'(bus.imem_req), 0);
      chk("halt_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("halt_we", 32'(bus.write_en), 0);
      @(posedge clk); #1;
    end
    bus.imem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("unhalt_halted", 32'(halted), 0);
    chk("unhalt_addr", 32'(bus.imem_addr), 0);
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("unhalt_req", 32'(bus.imem_req), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
